pixel_row_readout: RTL and testbench

// Parametrised successor to the pixel row: captures one row of parallel pixel words and streams them out one column per transfer.

---
 rtl/pixel_row_readout.sv | 147 ++++++++++++++
 tb/tb_pixel_row_readout.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_row_readout.sv
// pixel_row_readout
//   Captures one row of parallel pixel words on START and streams them out
//   one column per transfer, with valid/ready backpressure, a last-column
//   flag and overrun detection for STARTs that arrive mid-row.
//
// Optional feature macro: PIXEL_ROW_HEADER_EN
//   When defined, each row is preceded by a header word that carries
//   ROW_INDEX, flagged by OUT_HEADER.
//   When undefined, OUT_HEADER is constant 0.
//
// Ports
//   CLK        rising-edge clock
//   RESET      synchronous, active-high reset
//   START      1-cycle request: capture ROW_DATA and begin streaming
//   ROW_DATA   packed row; column i is ROW_DATA[i*PIXEL_BITS +: PIXEL_BITS]
//   OUT_DATA   current pixel word (or header word)
//   OUT_COL    column index of OUT_DATA
//   OUT_VALID  OUT_DATA/OUT_COL/OUT_LAST/OUT_HEADER are valid
//   OUT_READY  consumer accepts
//   OUT_LAST   current word is the last column
//   OUT_HEADER current word is the row header
//   BUSY       a row is in flight
//   OVERRUN    1-cycle pulse: a START was rejected
//   DBG_STATE  FSM state (0 idle, 1 stream, 2 header)
//
// Handshake: a word moves when OUT_VALID & OUT_READY on a rising edge.
// While OUT_VALID is high and OUT_READY is low, every output holds.
// OUT_VALID only drops after a transfer, or on reset.
module pixel_row_readout #(
  parameter int PIXEL_ARRAY_WIDTH = 2,
  parameter int PIXEL_BITS        = 8,
  parameter int ROW_INDEX         = 0,
  localparam int COL_BITS         = $clog2(PIXEL_ARRAY_WIDTH)
) (
  input  logic                                  CLK,
  input  logic                                  RESET,
  input  logic                                  START,
  input  logic [PIXEL_ARRAY_WIDTH*PIXEL_BITS-1:0] ROW_DATA,
  output logic [PIXEL_BITS-1:0]                 OUT_DATA,
  output logic [COL_BITS-1:0]                   OUT_COL,
  output logic                                  OUT_VALID,
  input  logic                                  OUT_READY,
  output logic                                  OUT_LAST,
  output logic                                  OUT_HEADER,
  output logic                                  BUSY,
  output logic                                  OVERRUN,
  output logic [1:0]                            DBG_STATE
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_HEADER = 2'd2
  } state_t;

  localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(PIXEL_ARRAY_WIDTH - 1);

`ifdef PIXEL_ROW_HEADER_EN
  localparam state_t FIRST_STATE = S_HEADER;
  // Truncates or zero-extends the row number to the pixel word width.
  localparam logic [PIXEL_BITS-1:0] HDR_WORD = PIXEL_BITS'(ROW_INDEX);
`else
  localparam state_t FIRST_STATE = S_STREAM;
`endif

  state_t                state_q, state_d;
  logic [PIXEL_BITS-1:0] cap_q [PIXEL_ARRAY_WIDTH];
  logic [COL_BITS-1:0]   col_q;
  logic                  overrun_q;

  logic last_col;
  logic last_xfer;
  logic accept;
  logic reject;

  assign last_col  = (col_q == LAST_COL);
  // The final word of the row is leaving this cycle.
  assign last_xfer = (state_q == S_STREAM) && last_col && OUT_READY;
  // A START is taken when idle, or back-to-back with the final transfer.
  assign accept    = START && ((state_q == S_IDLE) || last_xfer);
  assign reject    = START && (state_q != S_IDLE) && !last_xfer;

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (START) state_d = FIRST_STATE;
      S_HEADER: if (OUT_READY) state_d = S_STREAM;
      S_STREAM: if (last_xfer) state_d = START ? FIRST_STATE : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Capture register, column counter and overrun pulse
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < PIXEL_ARRAY_WIDTH; i++) cap_q[i] <= '0;
      col_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= reject;
      if (accept) begin
        for (int i = 0; i < PIXEL_ARRAY_WIDTH; i++)
          cap_q[i] <= ROW_DATA[i*PIXEL_BITS +: PIXEL_BITS];
        col_q <= '0;
      end else if ((state_q == S_STREAM) && OUT_READY && !last_col) begin
        // Stops at LAST_COL, so non-power-of-2 widths never run past the row.
        col_q <= col_q + 1'b1;
      end
    end
  end

  // Outputs
  always_comb begin
    OUT_DATA   = '0;
    OUT_COL    = '0;
    OUT_VALID  = 1'b0;
    OUT_LAST   = 1'b0;
    OUT_HEADER = 1'b0;
    case (state_q)
      S_STREAM: begin
        OUT_VALID = 1'b1;
        OUT_DATA  = cap_q[col_q];
        OUT_COL   = col_q;
        OUT_LAST  = last_col;
      end
`ifdef PIXEL_ROW_HEADER_EN
      S_HEADER: begin
        OUT_VALID  = 1'b1;
        OUT_DATA   = HDR_WORD;
        OUT_HEADER = 1'b1;
      end
`endif
      default: ;
    endcase
    BUSY      = (state_q != S_IDLE);
    OVERRUN   = overrun_q;
    DBG_STATE = state_q;
  end

endmodule

// File: tb/tb_pixel_row_readout.sv
// Bench for pixel_row_readout: two instances (W=4 row 0, W=5 row 3), a
// queue model of the words each row must deliver, a per-cycle compare
// process and directed scenarios with literal expectations.
module tb_pixel_row_readout;

`ifdef PIXEL_ROW_HEADER_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif
  localparam int HDR = HDR_EN ? 1 : 0;

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] col;
    logic       last;
    logic       hdr;
  } word_t;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        start     [2];
  logic        ready     [2];
  logic [39:0] row       [2];
  logic [7:0]  out_data  [2];
  logic [2:0]  out_col   [2];
  logic        out_valid [2];
  logic        out_last  [2];
  logic        out_hdr   [2];
  logic        busy      [2];
  logic        overrun   [2];
  logic [1:0]  dbg_state [2];

  int wid [2] = '{4, 5};
  int ridx[2] = '{0, 3};

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int W  = (g == 0) ? 4 : 5;
    localparam int RI = (g == 0) ? 0 : 3;
    logic [$clog2(W)-1:0] col_w;
    pixel_row_readout #(
      .PIXEL_ARRAY_WIDTH(W),
      .PIXEL_BITS(8),
      .ROW_INDEX(RI)
    ) u_dut (
      .CLK(clk),
      .RESET(reset),
      .START(start[g]),
      .ROW_DATA(row[g][W*8-1:0]),
      .OUT_DATA(out_data[g]),
      .OUT_COL(col_w),
      .OUT_VALID(out_valid[g]),
      .OUT_READY(ready[g]),
      .OUT_LAST(out_last[g]),
      .OUT_HEADER(out_hdr[g]),
      .BUSY(busy[g]),
      .OVERRUN(overrun[g]),
      .DBG_STATE(dbg_state[g])
    );
    assign out_col[g] = 3'(col_w);
  end

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each in-flight row is the list of words still owed to the consumer.
  word_t mq [2][$];
  bit    ov_exp [2];

  task automatic push_row(input int d);
    word_t w;
    if (HDR_EN) begin
      w.data = 8'(ridx[d]); w.col = 3'd0; w.last = 1'b0; w.hdr = 1'b1;
      mq[d].push_back(w);
    end
    for (int c = 0; c < wid[d]; c++) begin
      w.data = row[d][c*8 +: 8];
      w.col  = 3'(c);
      w.last = (c == wid[d] - 1);
      w.hdr  = 1'b0;
      mq[d].push_back(w);
    end
  endtask

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        mq[d].delete();
        ov_exp[d] = 1'b0;
      end else begin
        bit was_busy, xfer, last_x;
        was_busy = mq[d].size() > 0;
        xfer     = was_busy && ready[d];
        last_x   = xfer && (mq[d].size() == 1);
        if (xfer) void'(mq[d].pop_front());
        ov_exp[d] = 1'b0;
        if (start[d]) begin
          if (!was_busy || last_x) push_row(d);
          else ov_exp[d] = 1'b1;
        end
      end
    end
  end

  // scoreboard compare, every cycle, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        bit ev;
        ev = mq[d].size() > 0;
        chk($sformatf("d%0d_valid", d), 32'(out_valid[d]), 32'(ev));
        chk($sformatf("d%0d_busy", d), 32'(busy[d]), 32'(ev));
        chk($sformatf("d%0d_overrun", d), 32'(overrun[d]), 32'(ov_exp[d]));
        if (ev && out_valid[d]) begin
          chk($sformatf("d%0d_data", d), 32'(out_data[d]), 32'(mq[d][0].data));
          chk($sformatf("d%0d_col", d), 32'(out_col[d]), 32'(mq[d][0].col));
          chk($sformatf("d%0d_last", d), 32'(out_last[d]), 32'(mq[d][0].last));
          chk($sformatf("d%0d_header", d), 32'(out_hdr[d]), 32'(mq[d][0].hdr));
        end
      end
    end
  end

  // driver tasks
  task automatic cyc(input int d, input logic s, input logic r);
    start[d] = s;
    ready[d] = r;
    @(negedge clk);
    start[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    for (int i = 0; i < 30; i++) begin
      if (!out_valid[d]) break;
      cyc(d, 1'b0, 1'b1);
    end
    chk($sformatf("d%0d_drain_timeout", d), 32'(out_valid[d]), 32'd0);
  endtask

  task automatic chk_zero(input int d, input string tag);
    chk({tag, "_valid"}, 32'(out_valid[d]), 32'd0);
    chk({tag, "_data"},  32'(out_data[d]),  32'd0);
    chk({tag, "_col"},   32'(out_col[d]),   32'd0);
    chk({tag, "_last"},  32'(out_last[d]),  32'd0);
    chk({tag, "_hdr"},   32'(out_hdr[d]),   32'd0);
    chk({tag, "_busy"},  32'(busy[d]),      32'd0);
    chk({tag, "_ovr"},   32'(overrun[d]),   32'd0);
    chk({tag, "_state"}, 32'(dbg_state[d]), 32'd0);
  endtask

  logic rp [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0; ready[d] = 1'b1; row[d] = '0;
    end
    reset = 1'b1;
    // reset holds off a START presented with it
    start[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start[0] = 1'b0;
    chk_zero(0, "rst0");
    chk_zero(1, "rst1");
    reset  = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    // 1: full-throughput row
    row[0] = 40'h0044332211;
    cyc(0, 1'b1, 1'b1);
    chk("t1_first", 32'(out_data[0]), HDR_EN ? 32'h00 : 32'h11);
    chk("t1_valid", 32'(out_valid[0]), 32'd1);
    wait_idle(0);
    chk("t1_busy_low", 32'(busy[0]), 32'd0);

    // 2: stalls from a toggling ready
    cyc(0, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) cyc(0, 1'b0, rp[i]);
    wait_idle(0);

    // 3: back-to-back START on the last transfer
    cyc(0, 1'b1, 1'b1);
    for (int i = 0; i < wid[0] - 1 + HDR; i++) cyc(0, 1'b0, 1'b1);
    chk("t3_last_word", 32'(out_data[0]), 32'h44);
    chk("t3_last_flag", 32'(out_last[0]), 32'd1);
    row[0] = 40'h00DDCCBBAA;
    cyc(0, 1'b1, 1'b1);
    chk("t3_next_valid", 32'(out_valid[0]), 32'd1);
    chk("t3_next_word", 32'(out_data[0]), HDR_EN ? 32'h00 : 32'hAA);
    chk("t3_no_overrun", 32'(overrun[0]), 32'd0);
    wait_idle(0);

    // 4: START while column 1 is on the bus
    row[0] = 40'h0044332211;
    cyc(0, 1'b1, 1'b1);
    for (int i = 0; i < HDR + 1; i++) cyc(0, 1'b0, 1'b1);
    chk("t4_col1", 32'(out_data[0]), 32'h22);
    row[0] = 40'h00FFEEDDCC;
    cyc(0, 1'b1, 1'b1);
    chk("t4_overrun", 32'(overrun[0]), 32'd1);
    chk("t4_word", 32'(out_data[0]), 32'h33);
    cyc(0, 1'b0, 1'b1);
    chk("t4_overrun_pulse", 32'(overrun[0]), 32'd0);
    chk("t4_word2", 32'(out_data[0]), 32'h44);
    wait_idle(0);

    // 5: reset while column 2 is pending
    row[0] = 40'h0044332211;
    cyc(0, 1'b1, 1'b1);
    for (int i = 0; i < HDR + 2; i++) cyc(0, 1'b0, 1'b1);
    chk("t5_col2", 32'(out_col[0]), 32'd2);
    ready[0] = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    chk_zero(0, "t5_rst");
    cyc(0, 1'b0, 1'b1);
    chk("t5_stays_idle", 32'(out_valid[0]), 32'd0);
    cyc(0, 1'b1, 1'b1);
    chk("t5_fresh", 32'(out_data[0]), HDR_EN ? 32'h00 : 32'h11);
    wait_idle(0);

    // 6: five-column instance, row index 3
    row[1] = 40'h5E4D3C2B1A;
    cyc(1, 1'b1, 1'b1);
    chk("t6_first", 32'(out_data[1]), HDR_EN ? 32'h03 : 32'h1A);
    chk("t6_first_hdr", 32'(out_hdr[1]), 32'(HDR_EN));
    for (int i = 0; i < 6; i++) cyc(1, 1'b0, 1'(i % 2));
    wait_idle(1);
    row[1] = 40'h0102030405;
    cyc(1, 1'b1, 1'b1);
    for (int i = 0; i < 4 + HDR; i++) cyc(1, 1'b0, 1'b1);
    chk("t6_last_col", 32'(out_col[1]), 32'd4);
    chk("t6_last_flag", 32'(out_last[1]), 32'd1);
    chk("t6_last_word", 32'(out_data[1]), 32'h01);
    wait_idle(1);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
